dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Shares the single-port data memory between two requesters: the CPU load/store path and a debug/DMA port used for memory inspection and preload. CPU has fixed priority, and a starvation counter guarantees debug forward progress. The block drives the memory's MemRead/MemWrite/addr/WriteData, captures the combinational ReadData, and returns a registered response with an alignment-error flag to the granted requester.

Parameters:
MAX_WAIT, 4, consecutive denied cycles after which a waiting debug request beats the CPU (1..15)
CNT_W, 4, width of the starvation counter; must hold MAX_WAIT

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  CPU access request, held until granted
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  32  byte address
cpu_wdata  in  32  write data
cpu_gnt  out  1  combinational grant, same cycle as request
cpu_rvalid  out  1  response valid, one cycle after grant
cpu_rdata  out  32  read data (0 for writes and errors)
cpu_err  out  1  misaligned-access flag, qualified by cpu_rvalid
dbg_req, dbg_we, dbg_addr[31:0], dbg_wdata[31:0]  in  same meaning, debug side
dbg_gnt, dbg_rvalid, dbg_rdata[31:0], dbg_err  out  same meaning, debug side
MemRead  out  1  to memory
MemWrite  out  1  to memory
mem_addr  out  32  to memory addr
mem_wdata  out  32  to memory WriteData
ReadData  in  32  combinational read data from memory

Behaviour:
- Reset (async, rst_n=0): cpu/dbg_rvalid=0, cpu/dbg_rdata=0, cpu/dbg_err=0, starve_cnt=0, any pending response dropped. gnt, Mem* follow the combinational rules below and are 0 when no request is present.
- Selection, combinational, at most one grant per cycle:
  - only cpu_req -> CPU; only dbg_req -> DBG.
  - both -> CPU, unless starve_cnt == MAX_WAIT -> DBG.
  - neither -> no grant; MemRead=MemWrite=0, mem_addr=0, mem_wdata=0.
- Granted access, same cycle: mem_addr = granted addr, mem_wdata = granted wdata.
  - aligned (addr[1:0]==0): MemRead = !we, MemWrite = we.
  - misaligned: MemRead=MemWrite=0; the grant is still issued so the request retires.
- Response, registered at next rising edge after grant, valid 1 cycle only, granted side only:
  - rvalid=1.
  - rdata = ReadData for an aligned read, else 0.
  - err = 1 if misaligned.
  - Non-granted side rvalid=0; its rdata/err hold previous values.
- Requester rules:
  - req/we/addr/wdata stable while req=1 and gnt=0; requester may drop req only after gnt.
  - A new request may be presented in the cycle rvalid is high, giving back-to-back grants every cycle.
- starve_cnt, per clock:
  - dbg_req=1 and dbg_gnt=0 -> increment, saturating at MAX_WAIT.
  - dbg_gnt=1 or dbg_req=0 -> 0.
- Worst-case DBG wait under continuous CPU traffic: MAX_WAIT denied cycles, granted on cycle MAX_WAIT+1. The CPU is stalled exactly that one cycle.
- Write-then-read, same address, consecutive cycles: read returns the new data, because the memory write lands at the edge ending the write-grant cycle.
- Reset asserted mid-access: the memory write in that cycle is not guaranteed. The response is dropped, and the requester must reissue after reset.

Test Plan:
- Reset, then CPU write 0xDEADBEEF to 0x40, then read 0x40 -> cpu_gnt in both request cycles; MemWrite=1 then MemRead=1; cpu_rvalid one cycle after the read grant with cpu_rdata=0xDEADBEEF, cpu_err=0.
- DBG-only read of 0x44 after CPU write of 0x12345678 to 0x44 -> dbg_gnt same cycle; dbg_rdata=0x12345678 next cycle; cpu_rvalid stays 0.
- cpu_req held high continuously, dbg_req raised at cycle 0, MAX_WAIT=4 -> dbg denied cycles 0-3, dbg_gnt=1 and cpu_gnt=0 at cycle 4, starve_cnt returns to 0, CPU granted again at cycle 5.
- CPU read at 0x42 (misaligned) -> cpu_gnt=1, MemRead=MemWrite=0; next cycle cpu_rvalid=1, cpu_err=1, cpu_rdata=0. CPU write to 0x43 leaves memory unchanged (read back 0x40 unchanged).
- Simultaneous requests, starve_cnt < MAX_WAIT -> CPU granted. Back-to-back CPU reads at 0x00, 0x04, 0x08 -> three consecutive grants, and rvalid high three consecutive cycles with matching data.
- rst_n pulled low while cpu_rvalid pending (grant cycle edge) -> cpu_rvalid=0, rdata=0, starve_cnt=0 immediately, without waiting for clk. After release, a fresh request behaves normally.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus shared by the CPU load/store path and the debug/DMA port.
// The requester drives the request fields and the arbiter answers with a
// combinational grant plus a registered response one cycle later.
interface dmem_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the CPU and the debug/DMA port share one single-port
// memory. The CPU wins by default, but a debug request that has been denied
// MAX_WAIT cycles in a row takes the next slot, so debug always makes progress.
// Misaligned accesses are granted (so they retire) without touching memory,
// and come back with err set.
module dmem_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  cpu,
    dmem_arbiter_if.slave  dbg,
    output logic           MemRead,
    output logic           MemWrite,
    output logic [31:0]    mem_addr,
    output logic [31:0]    mem_wdata,
    input  logic [31:0]    ReadData
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             grant_cpu;
    logic             grant_dbg;
    logic             granted;
    logic             sel_we;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_wdata;
    logic             aligned;
    logic [31:0]      rdata_next;
    logic             err_next;

    // Pick at most one winner: CPU first, unless debug has waited long enough.
    always_comb begin
        grant_dbg = dbg.req && (!cpu.req || (starve_cnt == MAX_CNT));
        grant_cpu = cpu.req && !grant_dbg;
    end

    assign cpu.gnt = grant_cpu;
    assign dbg.gnt = grant_dbg;
    assign granted = grant_cpu || grant_dbg;

    // Route the winning requester's access onto the memory bus (zeros when idle).
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = 32'h0;
        sel_wdata = 32'h0;
        if (grant_cpu) begin
            sel_we    = cpu.we;
            sel_addr  = cpu.addr;
            sel_wdata = cpu.wdata;
        end else if (grant_dbg) begin
            sel_we    = dbg.we;
            sel_addr  = dbg.addr;
            sel_wdata = dbg.wdata;
        end
    end

    assign aligned   = (sel_addr[1:0] == 2'b00);
    assign MemRead   = granted && aligned && !sel_we;
    assign MemWrite  = granted && aligned && sel_we;
    assign mem_addr  = sel_addr;
    assign mem_wdata = sel_wdata;

    // Only an aligned read returns memory data; writes and errors return zero.
    assign rdata_next = (aligned && !sel_we) ? ReadData : 32'h0;
    assign err_next   = !aligned;

    // CPU response: one-cycle rvalid after a grant; data/err hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu.rvalid <= 1'b0;
            cpu.rdata  <= 32'h0;
            cpu.err    <= 1'b0;
        end else begin
            cpu.rvalid <= grant_cpu;
            if (grant_cpu) begin
                cpu.rdata <= rdata_next;
                cpu.err   <= err_next;
            end
        end
    end

    // Debug response: same shape as the CPU side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg.rvalid <= 1'b0;
            dbg.rdata  <= 32'h0;
            dbg.err    <= 1'b0;
        end else begin
            dbg.rvalid <= grant_dbg;
            if (grant_dbg) begin
                dbg.rdata <= rdata_next;
                dbg.err   <= err_next;
            end
        end
    end

    // Count consecutive denied debug cycles, saturating; clear on grant or idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!dbg.req || grant_dbg) begin
            starve_cnt <= '0;
        end else if (starve_cnt != MAX_CNT) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule
